dac_out_ctrl: RTL
=================

# dac_out_ctrl

Dual-channel DAC output stage sitting directly downstream of the FIR filter core. It accepts filtered signed 8-bit sample pairs (channel A/B) through a valid/ready handshake and buffers them in a 4-entry FIFO. It converts each sample to offset binary and replays the samples at a fixed update rate onto the parallel DAC pins (data, clock, write strobe, mode, sleep). It also counts underruns.

## Interface
- CLK_DIV, 4, system clocks per DAC update period; even, ≥ 2.
- PRIME_LEVEL, 2, FIFO entries required before output starts; 1..4.
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  output enable; 0 puts DAC to sleep and flushes buffer.
- s_valid  in  1  FIR output sample pair valid.
- s_ready  out  1  block can accept a pair.
- s_data_a  in  8  channel A sample, signed two's complement.
- s_data_b  in  8  channel B sample, signed two's complement.
- dac_mode  out  1  constant 1 (dual-port mode).
- dac_sleep  out  1  1 = DAC powered down.
- dac_clka / dac_clkb  out  1  DAC channel clocks (identical).
- dac_wra / dac_wrb  out  1  DAC write strobes (identical to clocks).
- dac_da / dac_db  out  8  DAC data, offset binary.
- underrun_cnt  out  8  saturating count of missed updates.

## Operation
- Reset values: state IDLE, FIFO empty, phase 0, dac_da = dac_db = 0x80, all dac_clk*/dac_wr* = 0, dac_sleep = 1, dac_mode = 1, underrun_cnt = 0, s_ready = 0.
- FIFO: 4 entries × 16 bits {a,b}, registered count 0..4. Push on s_valid && s_ready. s_ready = (state != IDLE) && (count < 4), decoded from registered state.
- Conversion at pop: out = {~d[7], d[6:0]}. So 0x80→0x00, 0x00→0x80, 0x7F→0xFF, 0xFF→0x7F.
- State machine:
  - IDLE: dac_sleep = 1, outputs at midscale, clocks low. When en = 1, go to PRIME next edge.
  - PRIME: dac_sleep = 0, accepts data, outputs hold 0x80 and clocks low. When count ≥ PRIME_LEVEL, go to RUN and set phase = 0.
  - RUN: phase counts 0..CLK_DIV-1 and wraps.
  - Any state with en = 0: go to IDLE next edge. This flushes the FIFO (count = 0), resets dac_da/db to 0x80, clocks/strobes to 0, dac_sleep to 1, and phase to 0. underrun_cnt is kept.
- RUN update cycle, evaluated on the edge where phase == 0:
  - If FIFO is non-empty: pop one pair and load dac_da/dac_db.
  - If FIFO is empty: hold previous dac_da/dac_db and increment underrun_cnt, saturating at 0xFF. State stays RUN.
  - In both cases clocks/strobes go to 0 at the same edge.
- At the edge where phase == CLK_DIV/2, clocks/strobes go to 1.
- A push and a pop on the same edge leave count unchanged. A push is never allowed at count = 4.
- underrun_cnt clears only on rst.

## Timing
- All outputs are registered; there is no combinational path from inputs to dac_* pins.
- Handshake: data is taken on the edge where s_valid && s_ready. s_valid may be held high indefinitely. s_data_* must be stable while s_valid is high and s_ready is low.
- Latency:
  - Sample pushed into an empty FIFO in PRIME with PRIME_LEVEL = 1: RUN is entered 1 edge after the push becomes visible in count.
  - First pop happens on the following phase-0 edge.
  - dac_da then changes 1 cycle later.
- In RUN, dac_da/db change exactly once per CLK_DIV cycles.
- dac_clk rises CLK_DIV/2 cycles after each data change and falls together with the next data change. This gives CLK_DIV/2 cycles of setup and hold.
- Sustained throughput: one pair per CLK_DIV cycles. Upstream faster than this sees s_ready = 0 when the FIFO is full.
- rst mid-RUN: all state returns to reset values on that edge, including underrun_cnt, and the FIFO contents are discarded.

## Test plan
- Reset: hold rst 3 cycles with en = 1 and s_valid = 1. Required: s_ready = 0, dac_da = dac_db = 0x80, clocks 0, dac_sleep = 1, dac_mode = 1, underrun_cnt = 0.
- Conversion and order (CLK_DIV = 4, PRIME_LEVEL = 2): push A = 0x00, 0x7F, 0x80, 0xFF with B = A. Required:
  - dac_da = dac_db sequence 0x80, 0xFF, 0x00, 0x7F, each held 4 cycles.
  - dac_clka rises 2 cycles after each change.
- Underrun: prime 2 pairs, then stop pushing. Required:
  - Last value held.
  - underrun_cnt increments by 1 every 4 cycles.
  - Clocks keep toggling.
  - After 300 periods, underrun_cnt = 0xFF.
- Backpressure: keep s_valid = 1 continuously with an incrementing value. Required:
  - s_ready drops when count = 4.
  - Exactly one accept per 4 cycles thereafter.
  - Output sequence has no gaps and no duplicates.
- Disable mid-RUN: set en = 0 with 3 entries buffered. Required, on the next cycle:
  - dac_sleep = 1, dac_da = 0x80, clocks 0, s_ready = 0.
  - On re-enable, the first output value is the first pair pushed after re-enable.
- Reset mid-RUN: assert rst during phase CLK_DIV/2 + 1. Required:
  - All outputs match reset values on the next cycle.
  - underrun_cnt = 0.

Source files
------------

// File: rtl/dac_out_ctrl.sv
// Dual-channel DAC output stage: 4-deep sample-pair FIFO behind a valid/ready
// port, replayed at one update per CLK_DIV clocks as offset-binary DAC words.

module dac_lane_conv (
    input  logic [7:0] d,
    output logic [7:0] q
);
    // Two's complement to offset binary is a flip of the sign bit.
    assign q = {~d[7], d[6:0]};
endmodule

module dac_out_ctrl #(
    parameter int CLK_DIV     = 4,
    parameter int PRIME_LEVEL = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data_a,
    input  logic [7:0] s_data_b,
    output logic       dac_mode,
    output logic       dac_sleep,
    output logic       dac_clka,
    output logic       dac_clkb,
    output logic       dac_wra,
    output logic       dac_wrb,
    output logic [7:0] dac_da,
    output logic [7:0] dac_db,
    output logic [7:0] underrun_cnt
);
    localparam int NUM_LANES = 2;
    localparam int VEC_W     = 8;
    localparam int DEPTH     = 4;
    localparam int PW        = $clog2(CLK_DIV);

    typedef struct packed {
        logic [VEC_W-1:0] a;
        logic [VEC_W-1:0] b;
    } pair_t;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t                             state, state_nxt;
    pair_t                              fifo_mem [DEPTH];
    logic [1:0]                         wr_ptr, rd_ptr;
    logic [2:0]                         count;
    logic [PW-1:0]                      phase;
    logic                               push, pop, upd;
    pair_t                              head;
    logic [NUM_LANES-1:0][VEC_W-1:0]    head_lanes, head_ob, dac_q;
    logic                               dac_clk_q;

    assign s_ready = (state != IDLE) && (count < 3'd4);
    assign push    = s_valid && s_ready;
    assign upd     = (state == RUN) && (phase == '0);
    assign pop     = upd && (count != 3'd0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = PRIME;
                PRIME:   if (count >= 3'(PRIME_LEVEL)) state_nxt = RUN;
                RUN:     state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{a: s_data_a, b: s_data_b};
    end

    // Disable flushes the buffer the same way reset does.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    assign head          = fifo_mem[rd_ptr];
    assign head_lanes[0] = head.a;
    assign head_lanes[1] = head.b;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        dac_lane_conv u_conv (
            .d (head_lanes[l]),
            .q (head_ob[l])
        );
    end

    // Data moves on phase 0 with the clock falling; the clock rises mid-period.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase        <= '0;
            dac_q        <= {NUM_LANES{8'h80}};
            dac_clk_q    <= 1'b0;
            dac_sleep    <= 1'b1;
            underrun_cnt <= '0;
        end else if (!en) begin
            phase     <= '0;
            dac_q     <= {NUM_LANES{8'h80}};
            dac_clk_q <= 1'b0;
            dac_sleep <= 1'b1;
        end else begin
            dac_sleep <= (state_nxt == IDLE);
            if (state == RUN) begin
                phase <= (phase == PW'(CLK_DIV - 1)) ? '0 : phase + PW'(1);
                if (upd) begin
                    dac_clk_q <= 1'b0;
                    if (pop)
                        dac_q <= head_ob;
                    else if (underrun_cnt != 8'hFF)
                        underrun_cnt <= underrun_cnt + 8'd1;
                end else if (phase == PW'(CLK_DIV / 2)) begin
                    dac_clk_q <= 1'b1;
                end
            end else begin
                phase <= '0;
            end
        end
    end

    assign dac_mode = 1'b1;
    assign dac_clka = dac_clk_q;
    assign dac_clkb = dac_clk_q;
    assign dac_wra  = dac_clk_q;
    assign dac_wrb  = dac_clk_q;
    assign dac_da   = dac_q[0];
    assign dac_db   = dac_q[1];
endmodule
